// File: rtl/dmem_ws.sv
// dmem_ws: word-organised data memory with byte/half/word access, load extension,
// and a wait-state stall handshake toward the pipeline memory stage.
// Each aligned access takes WAIT stall cycles followed by one ack cycle. Misaligned
// requests are acknowledged at once with no array access, and they raise a one-cycle
// misalign pulse in the following cycle.
module dmem_ws #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd,
  output logic        o_stall,
  output logic        o_ack,
  output logic        o_misalign,
  output logic [31:0] o_stall_cnt
);

  localparam int          Depth   = 1 << ADDR_W;
  localparam logic [3:0]  WaitCnt = 4'(WAIT);

  if (WAIT < 0 || WAIT > 15) begin : g_wait_range
    $error("dmem_ws: WAIT must be in 0..15");
  end

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              r_state, w_state_d;
  logic [3:0]          r_cnt, w_cnt_d;
  logic                r_misalign;
  logic [31:0]         r_stall_cnt;
  logic [31:0]         r_mem [Depth];

  logic [ADDR_W-1:0]   w_idx;
  logic [1:0]          w_lane;
  logic                w_misal;
  logic                w_done;      // aligned access completes this cycle
  logic                w_rej;       // misaligned request rejected this cycle
  logic                w_wr;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [31:0]         w_rword;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_ext;
  logic                w_unused_addr;

  // Address bits above the word index alias onto the same array.
  assign w_unused_addr = ^{i_addr[31:ADDR_W+2]};

  assign w_idx  = i_addr[ADDR_W+1:2];
  assign w_lane = i_addr[1:0];

  // Alignment check: size 11 never legal.
  always_comb begin
    unique case (i_size)
      2'b00:   w_misal = 1'b0;
      2'b01:   w_misal = i_addr[0];
      2'b10:   w_misal = (i_addr[1:0] != 2'b00);
      default: w_misal = 1'b1;
    endcase
  end

  // Sequencer next-state and handshake outputs; reset forces everything quiet.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    o_stall   = 1'b0;
    o_ack     = 1'b0;
    w_done    = 1'b0;
    w_rej     = 1'b0;
    if (!i_reset) begin
      unique case (r_state)
        StIdle: begin
          if (i_req) begin
            if (w_misal) begin
              o_ack = 1'b1;
              w_rej = 1'b1;
            end else if (WaitCnt == 4'd0) begin
              o_ack  = 1'b1;
              w_done = 1'b1;
            end else begin
              o_stall   = 1'b1;
              w_state_d = StBusy;
              w_cnt_d   = 4'd1;
            end
          end
        end
        StBusy: begin
          if (!i_req) begin
            // Pipeline flushed the access: abandon without writing.
            w_state_d = StIdle;
            w_cnt_d   = 4'd0;
          end else if (r_cnt == WaitCnt) begin
            o_ack     = 1'b1;
            w_done    = 1'b1;
            w_state_d = StIdle;
            w_cnt_d   = 4'd0;
          end else begin
            o_stall = 1'b1;
            w_cnt_d = r_cnt + 4'd1;
          end
        end
        default: begin
          w_state_d = StIdle;
          w_cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Sequencer state, wait counter, misalign pulse and saturating stall counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_misalign  <= 1'b0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_misalign <= w_rej;
      if (o_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign w_wr = w_done & i_we;

  // Store lane enables and lane-replicated write data.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = i_wd;
    unique case (i_size)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{i_wd[7:0]}};
      end
      2'b01: begin
        w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_wd[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wdata = i_wd;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = i_wd;
      end
    endcase
  end

  // Array write: only enabled lanes change; the array is never reset.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr && w_be[i]) begin
        r_mem[w_idx][i*8 +: 8] <= w_wdata[i*8 +: 8];
      end
    end
  end

  assign w_rword = r_mem[w_idx];

  // Load path: select lane, shift to bit 0, extend.
  always_comb begin
    w_byte = 8'(w_rword >> {w_lane, 3'b000});
    w_half = i_addr[1] ? w_rword[31:16] : w_rword[15:0];
    unique case (i_size)
      2'b00:   w_ext = {{24{i_sign_ext & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{i_sign_ext & w_half[15]}}, w_half};
      default: w_ext = w_rword;
    endcase
  end

  assign o_rd        = (w_done && !i_we) ? w_ext : 32'd0;
  assign o_misalign  = r_misalign;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_dmem_ws.sv
// Scoreboard bench for dmem_ws: three instances cover WAIT=2, WAIT=3 and WAIT=0/ADDR_W=4.
module tb_dmem_ws;

  logic        clk = 1'b0;
  logic        reset   [3];
  logic        req     [3];
  logic        we      [3];
  logic [1:0]  size    [3];
  logic        sx      [3];
  logic [31:0] addr    [3];
  logic [31:0] wd      [3];
  logic [31:0] rd      [3];
  logic        stall   [3];
  logic        ack     [3];
  logic        misal   [3];
  logic [31:0] scnt_o  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_ws #(
      .ADDR_W((g == 2) ? 4 : 8),
      .WAIT  ((g == 0) ? 2 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .i_clk      (clk),
      .i_reset    (reset[g]),
      .i_req      (req[g]),
      .i_we       (we[g]),
      .i_size     (size[g]),
      .i_sign_ext (sx[g]),
      .i_addr     (addr[g]),
      .i_wd       (wd[g]),
      .o_rd       (rd[g]),
      .o_stall    (stall[g]),
      .o_ack      (ack[g]),
      .o_misalign (misal[g]),
      .o_stall_cnt(scnt_o[g])
    );
  end

  typedef struct {
    int          k;
    bit          is_ld;
    logic [31:0] rd;
    int          stalls;
    bit          mis;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   stall_seen [3];
  bit   mis_pend   [3];
  bit   mis_exp    [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one access on instance k, push its expectation, hold until ack.
  task automatic access(input int k, input bit w, input logic [1:0] sz, input bit s,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input int exp_st, input bit exp_mis);
    exp_t e;
    int   n;
    e.k = k; e.is_ld = !w; e.rd = exp_rd; e.stalls = exp_st; e.mis = exp_mis;
    q.push_back(e);
    req[k] = 1'b1; we[k] = w; size[k] = sz; sx[k] = s; addr[k] = a; wd[k] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[k] && n < 40);
    if (!ack[k]) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack timeout inst %0d addr 0x%08h: got no ack, required ack", k, a);
    end
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  // Monitor: count stall cycles, compare on every ack, check misalign the cycle after.
  initial begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      stall_seen[k] = 0; mis_pend[k] = 1'b0; mis_exp[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (mis_pend[k]) begin
          chk($sformatf("misalign inst%0d", k), 32'(misal[k]), 32'(mis_exp[k]));
          mis_pend[k] = 1'b0;
        end
        if (!req[k] || reset[k]) stall_seen[k] = 0;
        else if (stall[k]) stall_seen[k]++;
        if (ack[k]) begin
          if (q.size() == 0) begin
            chk($sformatf("unexpected ack inst%0d", k), 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk($sformatf("ack instance inst%0d", k), 32'(k), 32'(e.k));
            if (e.is_ld) chk($sformatf("rd inst%0d addr 0x%08h", k, addr[k]), rd[k], e.rd);
            chk($sformatf("stall cycles inst%0d addr 0x%08h", k, addr[k]),
                32'(stall_seen[k]), 32'(e.stalls));
            mis_pend[k] = 1'b1;
            mis_exp[k]  = e.mis;
          end
          stall_seen[k] = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      reset[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; size[k] = 2'b10;
      sx[k] = 1'b0; addr[k] = 32'd0; wd[k] = 32'd0;
    end
    // Request held during reset must be ignored.
    req[0] = 1'b1; addr[0] = 32'h10;
    @(negedge clk);
    chk("reset stall", 32'(stall[0]), 32'd0);
    chk("reset ack", 32'(ack[0]), 32'd0);
    chk("reset rd", rd[0], 32'd0);
    chk("reset stall_cnt", scnt_o[0], 32'd0);
    chk("reset misalign", 32'(misal[0]), 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      reset[k] = 1'b0; req[k] = 1'b0;
    end
    @(posedge clk); #1;

    // WAIT=2: word store/load round trip.
    access(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 2, 0);
    access(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 2, 0);
    chk("stall_cnt after sw/lw", scnt_o[0], 32'd4);

    // Byte store into a known word, then signed/unsigned byte loads.
    access(0, 1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 2, 0);
    access(0, 1, 2'b00, 0, 32'h13, 32'h000000AA, 32'h0, 2, 0);
    access(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hAA223344, 2, 0);
    access(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFFFFAA, 2, 0);
    access(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'h000000AA, 2, 0);

    // Halfword store in upper lanes, then word/half loads.
    access(0, 1, 2'b10, 0, 32'h20, 32'h00000000, 32'h0, 2, 0);
    access(0, 1, 2'b01, 0, 32'h22, 32'h00008001, 32'h0, 2, 0);
    access(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h80010000, 2, 0);
    access(0, 0, 2'b01, 1, 32'h22, 32'h0, 32'hFFFF8001, 2, 0);
    access(0, 0, 2'b01, 0, 32'h22, 32'h0, 32'h00008001, 2, 0);

    // Misaligned requests: immediate ack, rd=0, misalign pulse, no write.
    access(0, 0, 2'b10, 0, 32'h05, 32'h0, 32'h0, 0, 1);
    access(0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 0, 1);
    access(0, 0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 0, 1);
    access(0, 1, 2'b10, 0, 32'h12, 32'h0, 32'h0, 0, 1);
    access(0, 1, 2'b01, 0, 32'h11, 32'h0, 32'h0, 0, 1);
    access(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hAA223344, 2, 0);
    chk("stall_cnt after sequence", scnt_o[0], 32'd26);

    // WAIT=3: set up two words.
    access(1, 1, 2'b10, 0, 32'h30, 32'h12345678, 32'h0, 3, 0);
    access(1, 1, 2'b10, 0, 32'h34, 32'h55555555, 32'h0, 3, 0);
    // Flush a store after two stall cycles.
    req[1] = 1'b1; we[1] = 1'b1; size[1] = 2'b10; addr[1] = 32'h30; wd[1] = 32'hCAFEF00D;
    @(negedge clk);
    chk("flush stall c0", 32'(stall[1]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush stall c1", 32'(stall[1]), 32'd1);
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(negedge clk);
    chk("flush stall", 32'(stall[1]), 32'd0);
    chk("flush ack", 32'(ack[1]), 32'd0);
    @(posedge clk); #1;
    access(1, 0, 2'b10, 0, 32'h30, 32'h0, 32'h12345678, 3, 0);

    // Reset in BUSY abandons the store.
    req[1] = 1'b1; we[1] = 1'b1; size[1] = 2'b10; addr[1] = 32'h34; wd[1] = 32'h0BADBEEF;
    @(negedge clk);
    chk("pre-reset stall", 32'(stall[1]), 32'd1);
    @(posedge clk); #1;
    reset[1] = 1'b1;
    @(negedge clk);
    chk("busy reset stall", 32'(stall[1]), 32'd0);
    chk("busy reset ack", 32'(ack[1]), 32'd0);
    chk("busy reset rd", rd[1], 32'd0);
    @(posedge clk); #1;
    reset[1] = 1'b0; req[1] = 1'b0;
    @(negedge clk);
    chk("busy reset stall_cnt", scnt_o[1], 32'd0);
    chk("post-reset stall", 32'(stall[1]), 32'd0);
    @(posedge clk); #1;
    access(1, 0, 2'b10, 0, 32'h34, 32'h0, 32'h55555555, 3, 0);
    chk("stall_cnt after reset load", scnt_o[1], 32'd3);

    // WAIT=0, ADDR_W=4: aliasing and no stalls.
    access(2, 1, 2'b10, 0, 32'h40, 32'h13579BDF, 32'h0, 0, 0);
    access(2, 0, 2'b10, 0, 32'h00, 32'h0, 32'h13579BDF, 0, 0);
    access(2, 0, 2'b00, 1, 32'h41, 32'h0, 32'hFFFFFF9B, 0, 0);
    chk("wait0 stall_cnt", scnt_o[2], 32'd0);

    repeat (3) @(posedge clk);
    chk("scoreboard empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
